// File: rtl/axis_decimate_pkg.sv
// Shared definitions for the stream decimator: KEEP/DROP state encoding and
// the drop-counter width helper.
package axis_decimate_pkg;

    typedef enum logic {
        ST_KEEP = 1'b0,
        ST_DROP = 1'b1
    } state_e;

    // Bits needed to count up to decim; never below 1 so DECIM_SIZE=0 still elaborates.
    function automatic int cnt_width(input int decim);
        int w;
        w = 1;
        while ((1 << w) < (decim + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/axis_decimate.sv
// AXI-stream decimator: keeps the first beat of every group of DECIM_SIZE+1
// input beats and emits it one cycle after the group's last accepted beat.
module axis_decimate
    import axis_decimate_pkg::*;
#(
    parameter int DECIM_SIZE = 19,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast
);

    localparam int              CNT_W     = cnt_width(DECIM_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DECIM_SIZE > 0) ? DECIM_SIZE - 1 : 0);
    localparam logic            PASS_THRU = (DECIM_SIZE == 0);

    state_e                r_state;
    state_e                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_last;

    logic w_s_ready;
    logic w_s_frame;
    logic w_m_frame;
    logic w_cnt_last;
    logic w_capture;
    logic w_emit;
    logic w_cnt_inc;
    logic w_cnt_clr;

    assign w_s_frame  = s_axis_tvalid & w_s_ready;
    assign w_m_frame  = r_valid & m_axis_tready;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_KEEP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_KEEP: begin
                if (w_s_frame && !s_axis_tlast && !PASS_THRU) begin
                    w_state_next = ST_DROP;
                end
            end
            ST_DROP: begin
                if (w_s_frame && (w_cnt_last || s_axis_tlast)) begin
                    w_state_next = ST_KEEP;
                end
            end
            default: w_state_next = ST_KEEP;
        endcase
    end

    // KEEP only accepts when the held sample can leave this cycle; DROP never stalls.
    always_comb begin
        w_s_ready = 1'b0;
        w_capture = 1'b0;
        w_emit    = 1'b0;
        w_cnt_inc = 1'b0;
        w_cnt_clr = 1'b0;
        case (r_state)
            ST_KEEP: begin
                w_s_ready = ~r_valid | m_axis_tready;
                w_capture = s_axis_tvalid & w_s_ready;
                w_cnt_clr = w_capture;
                w_emit    = w_capture & (s_axis_tlast | PASS_THRU);
            end
            ST_DROP: begin
                w_s_ready = 1'b1;
                if (s_axis_tvalid) begin
                    if (w_cnt_last || s_axis_tlast) begin
                        w_emit    = 1'b1;
                        w_cnt_clr = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_s_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_data <= s_axis_tdata;
            end
            // Re-arming on the same cycle as a drain keeps pass-through at full rate.
            if (w_emit) begin
                r_valid <= 1'b1;
                r_last  <= s_axis_tlast;
            end else if (w_m_frame) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tvalid = r_valid;
    assign m_axis_tdata  = r_data;
    assign m_axis_tlast  = r_last;

endmodule

// File: tb/tb_axis_decimate.sv
// Directed bench for axis_decimate: DECIM_SIZE=3 instance plus a DECIM_SIZE=0
// pass-through instance, with handshakes logged per clock edge.
module tb_axis_decimate;
    import axis_decimate_pkg::*;

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          c;
    } beat_t;

    logic clk;
    logic rst_n;

    logic        a_s_valid, a_s_ready, a_s_last, a_m_valid, a_m_ready, a_m_last;
    logic [31:0] a_s_data, a_m_data;
    logic        b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_last;
    logic [31:0] b_s_data, b_m_data;

    int checks;
    int failures;
    int cyc;

    beat_t in_a[$];
    beat_t out_a[$];
    beat_t in_b[$];
    beat_t out_b[$];

    axis_decimate #(.DECIM_SIZE(3), .DATA_WIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(a_s_valid), .s_axis_tready(a_s_ready),
        .s_axis_tdata(a_s_data), .s_axis_tlast(a_s_last),
        .m_axis_tvalid(a_m_valid), .m_axis_tready(a_m_ready),
        .m_axis_tdata(a_m_data), .m_axis_tlast(a_m_last)
    );

    axis_decimate #(.DECIM_SIZE(0), .DATA_WIDTH(32)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(b_s_valid), .s_axis_tready(b_s_ready),
        .s_axis_tdata(b_s_data), .s_axis_tlast(b_s_last),
        .m_axis_tvalid(b_m_valid), .m_axis_tready(b_m_ready),
        .m_axis_tdata(b_m_data), .m_axis_tlast(b_m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_s_valid && a_s_ready) in_a.push_back('{a_s_data, a_s_last, cyc});
        if (a_m_valid && a_m_ready) out_a.push_back('{a_m_data, a_m_last, cyc});
        if (b_s_valid && b_s_ready) in_b.push_back('{b_s_data, b_s_last, cyc});
        if (b_m_valid && b_m_ready) out_b.push_back('{b_m_data, b_m_last, cyc});
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] d, input logic l);
        int n;
        a_s_valid = 1'b1;
        a_s_data  = d;
        a_s_last  = l;
        n = 0;
        while (a_s_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL send_timeout data=%0h waited=%0d cycles, required accept within 50", d, n);
        end
        @(posedge clk);
        #1;
        a_s_valid = 1'b0;
        a_s_last  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(3);
        checks++;
        if (a_m_valid !== 1'b0 || a_m_last !== 1'b0 || a_m_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b l=%b d=%0h, required 0 0 0", a_m_valid, a_m_last, a_m_data);
        end
        checks++;
        if (a_s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_s_ready got %b, required 1", a_s_ready);
        end
        checks++;
        if (b_m_valid !== 1'b0 || b_m_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_b_outputs got v=%b d=%0h, required 0 0", b_m_valid, b_m_data);
        end
        rst_n = 1'b1;
        idle(2);
        checks++;
        if (a_m_valid !== 1'b0 || a_m_last !== 1'b0 || a_m_data !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_outputs got v=%b l=%b d=%0h, required 0 0 0", a_m_valid, a_m_last, a_m_data);
        end
    endtask

    task automatic test_continuous;
        in_a.delete();
        out_a.delete();
        a_m_ready = 1'b1;
        for (int i = 0; i < 12; i++) send_a(32'(i), 1'b0);
        idle(3);
        checks++;
        if (out_a.size() != 3 || in_a.size() != 12) begin
            failures++;
            $display("FAIL cont_count got out=%0d in=%0d, required 3 12", out_a.size(), in_a.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (out_a[k].d !== 32'(4 * k) || out_a[k].l !== 1'b0) begin
                    failures++;
                    $display("FAIL cont_data[%0d] got %0h/%b, required %0h/0", k, out_a[k].d, out_a[k].l, 4 * k);
                end
                checks++;
                if (out_a[k].c != in_a[4 * k + 3].c + 1) begin
                    failures++;
                    $display("FAIL cont_latency[%0d] got cycle %0d, required %0d", k, out_a[k].c, in_a[4 * k + 3].c + 1);
                end
            end
        end
    endtask

    task automatic test_tlast;
        in_a.delete();
        out_a.delete();
        for (int i = 0; i < 10; i++) send_a(32'(i), (i == 5));
        idle(3);
        checks++;
        if (out_a.size() != 3 || in_a.size() != 10) begin
            failures++;
            $display("FAIL tlast_count got out=%0d in=%0d, required 3 10", out_a.size(), in_a.size());
        end else begin
            checks++;
            if (out_a[0].d !== 32'd0 || out_a[0].l !== 1'b0) begin
                failures++;
                $display("FAIL tlast_first got %0h/%b, required 0/0", out_a[0].d, out_a[0].l);
            end
            checks++;
            if (out_a[1].d !== 32'd4 || out_a[1].l !== 1'b1 || out_a[1].c != in_a[5].c + 1) begin
                failures++;
                $display("FAIL tlast_partial got %0h/%b cyc %0d, required 4/1 cyc %0d",
                         out_a[1].d, out_a[1].l, out_a[1].c, in_a[5].c + 1);
            end
            checks++;
            if (out_a[2].d !== 32'd6 || out_a[2].l !== 1'b0 || out_a[2].c != in_a[9].c + 1) begin
                failures++;
                $display("FAIL tlast_newgroup got %0h/%b cyc %0d, required 6/0 cyc %0d",
                         out_a[2].d, out_a[2].l, out_a[2].c, in_a[9].c + 1);
            end
        end
    endtask

    task automatic test_single;
        in_a.delete();
        out_a.delete();
        send_a(32'hA5, 1'b1);
        checks++;
        if (a_m_valid !== 1'b1 || a_m_data !== 32'hA5 || a_m_last !== 1'b1) begin
            failures++;
            $display("FAIL single_out got v=%b d=%0h l=%b, required 1 a5 1", a_m_valid, a_m_data, a_m_last);
        end
        checks++;
        if (dut_a.r_state !== ST_KEEP) begin
            failures++;
            $display("FAIL single_state got %b, required KEEP", dut_a.r_state);
        end
        send_a(32'hA6, 1'b1);
        idle(2);
        checks++;
        if (out_a.size() != 2) begin
            failures++;
            $display("FAIL single_count got %0d, required 2", out_a.size());
        end else begin
            checks++;
            if (out_a[0].c != in_a[0].c + 1 || out_a[1].d !== 32'hA6 || out_a[1].l !== 1'b1) begin
                failures++;
                $display("FAIL single_seq got cyc %0d d1=%0h l1=%b, required cyc %0d a6 1",
                         out_a[0].c, out_a[1].d, out_a[1].l, in_a[0].c + 1);
            end
        end
    endtask

    task automatic test_backpressure;
        a_m_ready = 1'b0;
        send_a(32'h10, 1'b1);
        a_s_valid = 1'b1;
        a_s_data  = 32'h20;
        a_s_last  = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (a_s_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready[%0d] got %b, required 0", i, a_s_ready);
            end
            checks++;
            if (a_m_valid !== 1'b1 || a_m_data !== 32'h10 || a_m_last !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d] got v=%b d=%0h l=%b, required 1 10 1", i, a_m_valid, a_m_data, a_m_last);
            end
            @(posedge clk);
            #1;
        end
        in_a.delete();
        out_a.delete();
        a_m_ready = 1'b1;
        #1;
        checks++;
        if (a_s_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready got %b, required 1", a_s_ready);
        end
        @(posedge clk);
        #1;
        a_s_valid = 1'b0;
        a_s_last  = 1'b0;
        checks++;
        if (out_a.size() != 1 || in_a.size() != 1) begin
            failures++;
            $display("FAIL bp_same_cycle got out=%0d in=%0d, required 1 1", out_a.size(), in_a.size());
        end else if (out_a[0].d !== 32'h10 || out_a[0].c != in_a[0].c) begin
            failures++;
            $display("FAIL bp_same_cycle got d=%0h cyc %0d, required 10 cyc %0d", out_a[0].d, out_a[0].c, in_a[0].c);
        end
        checks++;
        if (a_m_valid !== 1'b1 || a_m_data !== 32'h20 || a_m_last !== 1'b1) begin
            failures++;
            $display("FAIL bp_next got v=%b d=%0h l=%b, required 1 20 1", a_m_valid, a_m_data, a_m_last);
        end
        idle(2);
        checks++;
        if (a_m_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain got v=%b, required 0", a_m_valid);
        end
    endtask

    task automatic test_reset_mid;
        out_a.delete();
        a_m_ready = 1'b0;
        send_a(32'h33, 1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_m_valid !== 1'b0 || a_m_data !== 32'h0 || a_m_last !== 1'b0) begin
            failures++;
            $display("FAIL rst_held got v=%b d=%0h l=%b, required 0 0 0", a_m_valid, a_m_data, a_m_last);
        end
        a_m_ready = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_a(32'd0, 1'b0);
        send_a(32'd1, 1'b0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        checks++;
        if (out_a.size() != 0 || a_m_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_output got count=%0d v=%b, required 0 0", out_a.size(), a_m_valid);
        end
        in_a.delete();
        for (int i = 7; i < 11; i++) send_a(32'(i), 1'b0);
        idle(3);
        checks++;
        if (out_a.size() != 1 || in_a.size() != 4) begin
            failures++;
            $display("FAIL rst_regroup_count got out=%0d in=%0d, required 1 4", out_a.size(), in_a.size());
        end else if (out_a[0].d !== 32'd7 || out_a[0].l !== 1'b0 || out_a[0].c != in_a[3].c + 1) begin
            failures++;
            $display("FAIL rst_regroup got %0h/%b cyc %0d, required 7/0 cyc %0d",
                     out_a[0].d, out_a[0].l, out_a[0].c, in_a[3].c + 1);
        end
    endtask

    task automatic test_passthrough;
        in_b.delete();
        out_b.delete();
        b_m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            b_s_valid = 1'b1;
            b_s_data  = 32'(i);
            checks++;
            if (b_s_ready !== 1'b1) begin
                failures++;
                $display("FAIL pt_ready[%0d] got %b, required 1", i, b_s_ready);
            end
            @(posedge clk);
            #1;
        end
        b_s_valid = 1'b0;
        idle(3);
        checks++;
        if (out_b.size() != 8 || in_b.size() != 8) begin
            failures++;
            $display("FAIL pt_count got out=%0d in=%0d, required 8 8", out_b.size(), in_b.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (out_b[k].d !== 32'(k + 1) || out_b[k].c != in_b[k].c + 1 || out_b[k].c != out_b[0].c + k) begin
                    failures++;
                    $display("FAIL pt_beat[%0d] got %0h cyc %0d, required %0h cyc %0d",
                             k, out_b[k].d, out_b[k].c, k + 1, in_b[k].c + 1);
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        a_s_valid = 1'b0; a_s_data = '0; a_s_last = 1'b0; a_m_ready = 1'b1;
        b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_m_ready = 1'b1;
        test_reset();
        test_continuous();
        test_tlast();
        test_single();
        test_backpressure();
        test_reset_mid();
        test_passthrough();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_decimate.md
AXIS_DECIMATE -- requirements
Module: axis_decimate

Interface
REQ-001 The module SHALL have parameter DECIM_SIZE, default 19: the number of input samples discarded after each kept sample; the decimation factor is DECIM_SIZE+1; legal range is 0..255.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32: the width of the tdata bus.
REQ-003 The module SHALL have port clk, input, width 1: the single clock; both AXI-stream channels share it.
REQ-004 The module SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-005 The module SHALL have port s_axis_tvalid, input, width 1: slave valid.
REQ-006 The module SHALL have port s_axis_tready, output, width 1: slave ready.
REQ-007 The module SHALL have port s_axis_tdata, input, width DATA_WIDTH: slave data.
REQ-008 The module SHALL have port s_axis_tlast, input, width 1: marks the last input sample of a burst.
REQ-009 The module SHALL have port m_axis_tvalid, output, width 1: master valid.
REQ-010 The module SHALL have port m_axis_tready, input, width 1: master ready.
REQ-011 The module SHALL have port m_axis_tdata, output, width DATA_WIDTH: master data.
REQ-012 The module SHALL have port m_axis_tlast, output, width 1: marks the last output sample of a burst.

Function
REQ-013 A slave beat (s_frame) SHALL be counted only when s_axis_tvalid and s_axis_tready are both high; a master beat (m_frame) SHALL be counted only when m_axis_tvalid and m_axis_tready are both high.
REQ-014 Input beats SHALL be grouped into groups of DECIM_SIZE+1; group 1 begins with the first beat after reset.
REQ-015 A new group SHALL begin after every s_axis_tlast beat, even if the current group is partial.
REQ-016 The first beat of each group SHALL be kept; every other beat in the group SHALL be discarded.
REQ-017 The block SHALL use a two-state FSM: KEEP (waiting for the first beat of a group) and DROP (discarding the rest of the group).
REQ-018 The block SHALL use a drop counter of width log2(DECIM_SIZE+1), reset to 0.
REQ-019 In KEEP, s_axis_tready SHALL equal (!m_axis_tvalid | m_axis_tready).
REQ-020 In KEEP, on s_frame, the output register SHALL capture s_axis_tdata and the drop counter SHALL clear.
REQ-021 In KEEP, on s_frame with s_axis_tlast=1 or DECIM_SIZE=0, the block SHALL set m_axis_tvalid=1 next cycle, set m_axis_tlast to the beat's tlast, and stay in KEEP; otherwise it SHALL go to DROP.
REQ-022 In DROP, s_axis_tready SHALL be 1 and m_axis_tvalid SHALL be 0.
REQ-023 In DROP, each s_frame SHALL increment the drop counter.
REQ-024 In DROP, on the s_frame where the counter equals DECIM_SIZE-1 or s_axis_tlast=1, the block SHALL set m_axis_tvalid=1 next cycle, set m_axis_tlast to that beat's tlast, and go to KEEP.
REQ-025 Output latency SHALL be exactly one cycle after the last accepted beat of a group.
REQ-026 At most one kept sample SHALL be held at any time.
REQ-027 m_axis_tvalid SHALL clear on m_frame unless the same cycle sets it again (KEEP with DECIM_SIZE=0 or tlast).
REQ-028 m_axis_tdata and m_axis_tlast SHALL remain stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-029 Discarded tdata SHALL never appear on m_axis_tdata.
REQ-030 With DECIM_SIZE=0, the block SHALL behave as a registered pass-through that sustains one beat per cycle when m_axis_tready=1.
REQ-031 The drop counter SHALL never exceed DECIM_SIZE-1 and SHALL not wrap.

Reset
REQ-032 On rst_n=0 the state SHALL be KEEP, the drop counter 0, and the output data register 0.
REQ-033 During and after reset, m_axis_tvalid, m_axis_tlast and m_axis_tdata SHALL be 0.
REQ-034 Deasserting reset SHALL take effect synchronously to clk.
REQ-035 Reset mid-group or while a sample is held SHALL discard all state without emitting any output.

Structure
REQ-036 The log2 width function and the KEEP/DROP state encodings SHALL reside in the shared include already used by the peak blocks.
REQ-037 The block SHALL be flat, with no sub-module.

Verification (DECIM_SIZE=3, DATA_WIDTH=32)
REQ-038 Input 0..11 continuous with m_axis_tready=1 and no tlast -> output 0, 4, 8 with m_axis_tlast=0; each appears one cycle after inputs 3, 7 and 11 respectively.
REQ-039 Input 0..5 with tlast on input 5 -> output 0 (tlast=0), then 4 (tlast=1) one cycle after input 5; input 6 starts a new group and is kept.
REQ-040 Input a single beat 0xA5 with tlast=1 -> output 0xA5 with tlast=1 one cycle later, FSM stays in KEEP.
REQ-041 With an output held and m_axis_tready=0 for 10 cycles, next input presented -> s_axis_tready=0 in KEEP, data stable; on m_axis_tready=1 the beat is accepted the same cycle.
REQ-042 rst_n pulsed low in DROP after inputs 0, 1 -> no output; next input 7 is kept, then 7 emitted after 3 further beats.
REQ-043 Rebuild with DECIM_SIZE=0, stream 1..8 with m_axis_tready=1 -> output 1..8 back-to-back with one cycle of latency.
